sap1_controller_sequencer: RTL
==============================

// Module: sap1_controller_sequencer
// PURPOSE
// - SAP-1 controller-sequencer. Six-state ring counter (T1..T6) plus instruction decoder.
// - Drives the 12-bit control word CON that sequences the datapath:
//   PC (Cp/Ep), MAR, RAM, IR, accumulator, adder/subtractor, B register, output register.
// - Sits between the IR opcode nibble and every datapath load/enable pin.
// - Also raises HLT, which gates the system clock off.
// PARAMETERS
// - OP_LDA   4'h0  LDA opcode
// - OP_ADD   4'h1  ADD opcode
// - OP_SUB   4'h2  SUB opcode
// - OP_OUT   4'hE  OUT opcode
// - OP_HLT   4'hF  HLT opcode
// PORTS
// - CLK     in   1   system clock; all state updates on the FALLING edge, so CON is stable at datapath rising edges
// - CLR     in   1   reset, asynchronous, active-high
// - opcode  in   4   IR[7:4]; sampled combinationally in T4..T6 only
// - T       out  6   one-hot ring state; T[0]=T1 .. T[5]=T6
// - CON     out  12  {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
// - HLT     out  1   halted flag, active-high
// BEHAVIOUR
// - Reset
//   - CLR high: T=6'b000001, HLT=0, CON=12'h3E3 (all inactive), regardless of CLK.
// - Ring counter
//   - Each falling edge: T1->T2->...->T6->T1.
//   - Always exactly one bit of T set.
// - CON decode (combinational from T, opcode, HLT; forced to 3E3 while CLR):
//   - Fetch (all opcodes): T1=5E3 (Ep, Lm_bar low); T2=BE3 (Cp); T3=263 (CE_bar, Li_bar low).
//   - LDA: T4=1A3, T5=2C3, T6=3E3.
//   - ADD: T4=1A3, T5=2E1, T6=3C7.
//   - SUB: T4=1A3, T5=2E1, T6=3CF (Su additionally set).
//   - OUT: T4=3F2, T5=3E3, T6=3E3.
//   - Undefined opcode: NOP; 3E3 in T4..T6, no error flag.
// - Halt
//   - HLT opcode in T4: HLT sets on that falling edge.
//   - Ring then freezes at T5.
//   - CON = 3E3 while HLT=1.
//   - Only CLR clears HLT.
//   - HLT is never set during T1..T3, regardless of opcode.
// - Latency
//   - CLR deassert -> T1 word on CON immediately (combinational).
//   - T2 after the first falling edge.
//   - Instruction = 6 clocks (fixed mode).
// - Boundary conditions
//   - CLR mid-instruction (any T, any opcode, halted or not): immediate return to T1 state.
//     Partially issued loads are abandoned.
//   - CLR asserted on a falling edge: CLR wins.
//   - Opcode changing during T1..T3: ignored.
//   - Opcode changing mid-execute is not legal: decode follows the live value, no latching.
// - No glitches on CON: decode only from registered T/HLT plus the stable opcode.
// CONFIGURATION
// - SAP1_VARCYCLE_EN defined: variable machine cycle. Ring returns to T1 on the falling edge after:
//   - T4 for OUT and undefined opcodes;
//   - T5 for LDA;
//   - T6 for ADD/SUB.
//   - HLT unchanged.
//   - Cycles per instruction: OUT/NOP=4, LDA=5, ADD/SUB=6.
// - Not defined: fixed 6-state ring for every opcode, as above.
// TESTING
// - Reset: CLR=1 for 100 time units with CLK toggling -> T=000001, CON=3E3, HLT=0 throughout.
//   After release, CON=5E3 until first falling edge.
// - LDA: opcode=0 -> CON sequence 5E3,BE3,263,1A3,2C3,3E3, then 5E3 again; T walks 01,02,04,08,10,20.
// - ADD/SUB back to back: ADD -> T6=3C7; then SUB -> T6=3CF. Fetch words identical both instructions.
// - OUT then HLT: OUT T4=3F2. Then opcode=F -> HLT=1 after T4 edge, T stays 010000, CON=3E3 for 20 clocks.
//   CLR pulse -> HLT=0, T=000001.
// - Mid-op reset: assert CLR asynchronously during ADD T5 (between edges) -> CON drops to 3E3, T=000001 within same cycle.
// - SAP1_VARCYCLE_EN build: OUT -> 4-clock cycle (T4 -> T1); LDA -> 5 clocks; ADD -> 6.
//   Undefined opcode 4'h7 -> 4 clocks, CON=3E3 in T4.

Source files
------------

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer: SAP-1 T1..T6 ring counter plus decoder driving CON/HLT from CLK/CLR/opcode; SAP1_VARCYCLE_EN shortens cycles
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [3:0]  opcode,
  output logic [5:0]  T,
  output logic [11:0] CON,
  output logic        HLT
);
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [11:0] IDLE = 12'h3E3;
  logic [5:0] t_q, t_d;
  logic hlt_q, hlt_d;
  logic lda, add, sub, out, hlt_op, wrap;
  logic [11:0] con_t4, con_t5, con_t6;
  assign lda = opcode == OP_LDA;
  assign add = opcode == OP_ADD;
  assign sub = opcode == OP_SUB;
  assign out = opcode == OP_OUT;
  assign hlt_op = opcode == OP_HLT;
`ifdef SAP1_VARCYCLE_EN
  assign wrap = !hlt_q && ((t_q[3] && !(lda || add || sub || hlt_op)) || (t_q[4] && lda));
`else
  assign wrap = 1'b0;
`endif
  assign t_d = hlt_q ? t_q : wrap ? T1 : {t_q[4:0], t_q[5]};
  assign hlt_d = hlt_q | (t_q[3] & hlt_op);
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      t_q <= T1;
      hlt_q <= 1'b0;
    end else begin
      t_q <= t_d;
      hlt_q <= hlt_d;
    end
  end
  always_comb begin
    con_t4 = (lda || add || sub) ? 12'h1A3 : out ? 12'h3F2 : IDLE;
    con_t5 = lda ? 12'h2C3 : (add || sub) ? 12'h2E1 : IDLE;
    con_t6 = add ? 12'h3C7 : sub ? 12'h3CF : IDLE;
    CON = (CLR || hlt_q) ? IDLE :
          t_q[0] ? 12'h5E3 :
          t_q[1] ? 12'hBE3 :
          t_q[2] ? 12'h263 :
          t_q[3] ? con_t4 :
          t_q[4] ? con_t5 :
          t_q[5] ? con_t6 : IDLE;
  end
  assign T = t_q;
  assign HLT = hlt_q;
endmodule
